// File: rtl/if_stage_oq_pkg.sv
// Shared definitions for the multi-outstanding fetch stage: bus widths,
// exception code and the layout of one fetched entry.
package if_stage_oq_pkg;
  localparam int          FS_TO_DS_BUS_WD  = 65;
  localparam logic [4:0]  EXC_ADEL         = 5'h04;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;

  typedef struct packed {
    logic        adel;
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_entry_t;
endpackage

// File: rtl/if_stage_oq_fetch_fifo.sv
// In-order fetch queue; clear wins over push/pop, push+pop in one cycle is legal.
module if_stage_oq_fetch_fifo
  import if_stage_oq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  fs_entry_t              din,
  output logic [$clog2(DEPTH):0] count,
  output fs_entry_t              head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  fs_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop & (count_q != '0);
    do_push  = push & ((count_q != FULL) | do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/if_stage_oq.sv
// IF stage with up to MAX_OUTST in-flight fetches, credit-based issue into a
// DEPTH-entry queue, and redirect with cancellation of stale responses.
module if_stage_oq
  import if_stage_oq_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_req,
  output logic                       inst_sram_wr,
  output logic [1:0]                 inst_sram_size,
  output logic [3:0]                 inst_sram_wen,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [OW-1:0] outst_q, outst_d, cancel_q, cancel_d;
  logic          stop_q, stop_d;
  logic [CW-1:0] count;
  fs_entry_t     head, push_data;
  logic          push, pop, clear, accept, resp_ok;
  int            live;

  always_comb begin
    live    = int'(outst_q) - int'(cancel_q);
    // Credit: every live request already owns a queue slot, so pushes never overflow.
    inst_sram_req = ~reset & ~redirect_valid & ~stop_q & (fetch_pc_q[1:0] == 2'b00)
                  & (int'(outst_q) < MAX_OUTST) & ((int'(count) + live) < DEPTH);
    accept  = inst_sram_req & inst_sram_addr_ok;
    resp_ok = inst_sram_data_ok & (outst_q != '0);
    fs_to_ds_valid = ~reset & (count != '0);
    pop     = fs_to_ds_valid & ds_allowin & ~redirect_valid;
    clear   = reset | redirect_valid;

    fetch_pc_d = accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q + OW'(accept) - OW'(resp_ok);
    cancel_d   = cancel_q;
    stop_d     = stop_q;
    push       = 1'b0;
    push_data  = '0;

    if (resp_ok) begin
      if (cancel_q != '0) begin
        cancel_d = cancel_q - 1'b1;
      end else begin
        push      = 1'b1;
        push_data = '{adel: 1'b0, inst: inst_sram_rdata, pc: resp_pc_q};
        resp_pc_d = resp_pc_q + 32'd4;
      end
    end

    // Misaligned target: emit one ADEL marker once nothing live is ahead of it.
    if (fetch_pc_q[1:0] != 2'b00 && !stop_q && live == 0 && int'(count) < DEPTH) begin
      push      = 1'b1;
      push_data = '{adel: 1'b1, inst: 32'h0, pc: fetch_pc_q};
      stop_d    = 1'b1;
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      stop_d     = 1'b0;
      cancel_d   = outst_q - OW'(resp_ok);
      push       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      cancel_q   <= '0;
      stop_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      cancel_q   <= cancel_d;
      stop_q     <= stop_d;
    end
  end

  if_stage_oq_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (push_data),
    .count (count),
    .head  (head)
  );

  assign fs_to_ds_bus    = head;
  assign inst_sram_addr  = fetch_pc_q;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_wdata = 32'h0;
endmodule

// File: doc/if_stage_oq.md
Name: if_stage_oq

Overview:
- Parametrised successor IF stage: keeps up to MAX_OUTST instruction requests in flight on the SRAM-like bus and buffers returned words in a DEPTH-entry in-order queue ahead of decode.
- Sits between the branch/exception redirect logic and ID. Replaces the single-outstanding, stall-on-every-fetch IF.
- Supports a generic redirect (branch target, exception entry, ERET, TLB refetch) with cancellation of stale in-flight responses.

Parameters:
- DEPTH, 4, instruction queue entries (power of 2, ≥2).
- MAX_OUTST, 2, max in-flight requests (1..DEPTH).
- RESET_PC, 32'hbfc00000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ds_allowin  in  1  ID accepts an entry this cycle.
- redirect_valid  in  1  flush and refetch; upstream resolves priority (EX > TLB > ERET > branch) and guarantees any delay slot has already left this block.
- redirect_pc  in  32  new fetch address.
- fs_to_ds_valid  out  1  queue head valid.
- fs_to_ds_bus  out  65  {adel, inst[31:0], pc[31:0]}; width macro FS_TO_DS_BUS_WD = 65.
- inst_sram_req  out  1  request.
- inst_sram_wr  out  1  constant 0.
- inst_sram_size  out  2  constant 2'b10.
- inst_sram_wen  out  4  constant 0.
- inst_sram_addr  out  32  fetch_pc.
- inst_sram_wdata  out  32  constant 0.
- inst_sram_addr_ok  in  1  request accepted.
- inst_sram_data_ok  in  1  response valid; responses return in request order.
- inst_sram_rdata  in  32  response data.

Behaviour:
State:
- fetch_pc resets to RESET_PC.
- resp_pc resets to RESET_PC; it is the PC of the next non-cancelled response.
- outst (0..MAX_OUTST) counts all in-flight requests, cancelled ones included.
- cancel_cnt (0..MAX_OUTST) counts in-flight responses still to be dropped.
- Queue count is 0..DEPTH.
- Reset clears outst, cancel_cnt and the queue. fs_to_ds_valid=0 and inst_sram_req=0 during reset. The bus bridge is reset in the same cycle.

Issue:
- inst_sram_req = ~reset & ~redirect_valid & ~stop & fetch_pc[1:0]==0 & outst<MAX_OUTST & (count+outst-cancel_cnt)<DEPTH.
- The last term is a credit check: every live response is guaranteed a queue slot, so the queue never overflows.
- On req & addr_ok: fetch_pc += 4 (mod 2^32 wrap), outst += 1.

Response:
- On data_ok: outst -= 1.
- If cancel_cnt>0: cancel_cnt -= 1 and drop the word.
- Otherwise push {0, rdata, resp_pc} and resp_pc += 4.
- A pushed entry is visible at fs_to_ds_valid the next cycle (1-cycle registered latency).

Misaligned PC:
- If fetch_pc[1:0]!=0, no request is issued.
- When outst-cancel_cnt==0 and the queue is not full, push {1, 32'h0, fetch_pc} once.
- Then set stop=1; no further fetch until redirect.
- ID raises ADEL with BadVAddr=pc.

Dequeue:
- The head pops when fs_to_ds_valid & ds_allowin.
- Push and pop in the same cycle are both performed; count is unchanged.

Redirect (highest priority, same cycle):
- Queue cleared; a pop in that cycle is ignored.
- fetch_pc ← redirect_pc, resp_pc ← redirect_pc, stop ← 0.
- cancel_cnt ← outst − data_ok, using the pre-cycle outst; a data_ok in the redirect cycle is always dropped.
- Request output is low in the redirect cycle, so no addr_ok can coincide with it.
- Issue resumes the next cycle, while old responses are still draining. Credit counts only live requests.
- Back-to-back redirects recompute cancel_cnt each time.

Decomposition:
- mycpu.h: FS_TO_DS_BUS_WD, ADEL code, RESET_PC default.
- Sub-module fetch_fifo: DEPTH×65 synchronous FIFO.
  - Inputs: push, pop, clear.
  - Outputs: count, head.
  - Same-cycle push+pop is legal; clear has priority.
- Counters and the issue/cancel logic stay in if_stage_oq.

Test Plan:
- Zero-wait bridge (addr_ok=1, data_ok 1 cycle later), ds_allowin=1 → 0xbfc00000, 0xbfc00004, … issued every cycle, 2 in flight, one entry delivered per cycle in order.
- ds_allowin=0 for 10 cycles with DEPTH=4, MAX_OUTST=2 → queue holds 4 entries, req stays low, no data_ok lost. Then release → the 4 entries drain in PC order and fetch resumes.
- Redirect to 0x80001000 with outst=2 and queue=3 → queue empty next cycle, the next 2 data_ok dropped, first delivered entry pc=0x80001000.
- Redirect in the same cycle as data_ok with outst=1 → cancel_cnt=0, no drop of later data, first delivered pc = redirect_pc.
- Redirect to 0x80000002 → no req, single entry {adel=1, pc=0x80000002}, fetch stops. A second redirect to 0xbfc00380 → normal fetch resumes.
- Assert reset for 1 cycle mid-burst → next cycle req addresses 0xbfc00000, outst=0, queue empty.
